// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and FSM state for the 640x480 VGA
// sync generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Display-side timing bundle: sync pulses, blanking and pixel coordinates.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   frame_start;
  logic   line_end;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_start, line_end
  );

  modport slave (
    input hsync, vsync, video_on, pixel_x, pixel_y, frame_start, line_end
  );

endinterface

// File: rtl/vga_sync_gen_wrap_counter.sv
// Modulo-N counter with enable and synchronous clear; exposes its next value so
// downstream decode can be registered in the same stage as the count.
module wrap_counter #(
  parameter int unsigned N     = 800,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_d_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // High on the enabled cycle whose edge takes the count back to zero.
  assign wrap_o = en_i && (count_q == LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters plus registered sync, blank and
// pulse outputs decoded from the next counter state so everything stays aligned.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic            clk_d,
  input  logic            rst_n,
  vga_sync_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_bad_totals
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  state_e state_q;
  logic   cnt_en;
  logic   cnt_clr;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   h_wrap;
  logic   v_wrap;

  assign cnt_en  = (state_q == RUN);
  assign cnt_clr = (state_q == HOLD);

  wrap_counter #(.N(H_TOTAL), .WIDTH(COORD_W)) u_h_cnt (
    .clk       (clk_d),
    .rst_n     (rst_n),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .count_o   (x_q),
    .count_d_o (x_d),
    .wrap_o    (h_wrap)
  );

  wrap_counter #(.N(V_TOTAL), .WIDTH(COORD_W)) u_v_cnt (
    .clk       (clk_d),
    .rst_n     (rst_n),
    .en_i      (h_wrap),
    .clr_i     (cnt_clr),
    .count_o   (y_q),
    .count_d_o (y_d),
    .wrap_o    (v_wrap)
  );

  // A frame only ends on the last pixel of the last line.
  a_frame_wrap_on_line_wrap : assert property (
    @(posedge clk_d) disable iff (!rst_n) v_wrap |-> h_wrap
  );

  logic hsync_d, vsync_d, video_on_d, frame_start_d, line_end_d;
  logic hsync_q, vsync_q, video_on_q, frame_start_q, line_end_q;

  always_comb begin
    hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    frame_start_d = (x_d == '0) && (y_d == '0);
    line_end_d    = (x_d == H_LAST);
  end

  // HOLD lasts one clock after reset release; the counters sit at (0,0) meanwhile.
  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      state_q       <= HOLD;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      state_q       <= RUN;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.frame_start = frame_start_q;
  assign vga.line_end    = line_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default-timing instance for the line
// behaviour and reset, reduced-timing instance for vertical sync and frame wrap.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic       le;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  } tim_t;

  typedef struct {
    bit run;
    int x;
    int y;
  } mdl_t;

  // flags order: hsync, vsync, video_on, line_end, frame_start
  typedef struct {
    int       x;
    int       y;
    bit [4:0] f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #20 clk = ~clk;

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();

  vga_sync_gen u_dut (
    .clk_d (clk),
    .rst_n (rst_n),
    .vga   (vga_a)
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (1)
  ) u_small (
    .clk_d (clk),
    .rst_n (rst_n),
    .vga   (vga_b)
  );

  obs_t act_a, act_b;
  assign act_a = {vga_a.hsync, vga_a.vsync, vga_a.video_on, vga_a.frame_start,
                  vga_a.line_end, vga_a.pixel_x, vga_a.pixel_y};
  assign act_b = {vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.frame_start,
                  vga_b.line_end, vga_b.pixel_x, vga_b.pixel_y};

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t q_a[$];
  obs_t q_b[$];
  mdl_t m_a, m_b;
  tim_t tim_a, tim_b;
  vec_t vecs_a[11];
  vec_t vecs_b[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t decode(input tim_t t, input int x, input int y);
    obs_t o;
    int hs0 = t.ha + t.hfp;
    int vs0 = t.va + t.vfp;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = !((x >= hs0) && (x < hs0 + t.hsw));
    o.vs  = !((y >= vs0) && (y < vs0 + t.vsw));
    o.von = (x < t.ha) && (y < t.va);
    o.fs  = (x == 0) && (y == 0);
    o.le  = (x == t.ha + t.hfp + t.hsw + t.hbp - 1);
    return o;
  endfunction

  function automatic obs_t advance(input tim_t t, input logic rst_v, inout mdl_t m);
    int htot = t.ha + t.hfp + t.hsw + t.hbp;
    int vtot = t.va + t.vfp + t.vsw + t.vbp;
    if (!rst_v) begin
      m.run = 1'b0;
      m.x   = 0;
      m.y   = 0;
      return reset_obs();
    end
    if (!m.run) begin
      m.run = 1'b1;
      m.x   = 0;
      m.y   = 0;
    end else if (m.x == htot - 1) begin
      m.x = 0;
      m.y = (m.y == vtot - 1) ? 0 : m.y + 1;
    end else begin
      m.x = m.x + 1;
    end
    return decode(t, m.x, m.y);
  endfunction

  // Push the expectation for the coming edge, then compare after it.
  task automatic tick();
    obs_t ea, eb, pa, pb;
    ea = advance(tim_a, rst_n, m_a);
    q_a.push_back(ea);
    eb = advance(tim_b, rst_n, m_b);
    q_b.push_back(eb);
    @(posedge clk);
    @(negedge clk);
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    check($sformatf("scb_a(%0d,%0d)", pa.x, pa.y), 32'(act_a), 32'(pa));
    check($sformatf("scb_b(%0d,%0d)", pb.x, pb.y), 32'(act_b), 32'(pb));
  endtask

  task automatic run_to(input bit use_b, input int x, input int y);
    int n = 0;
    while (!(use_b ? (m_b.run && m_b.x == x && m_b.y == y)
                   : (m_a.run && m_a.x == x && m_a.y == y))) begin
      if (n >= 2000) begin
        $display("FAIL run_to(%0d,%0d): position not reached, got none, expected reach", x, y);
        $fatal(1, "bench stepping bound exceeded");
      end
      tick();
      n++;
    end
  endtask

  initial begin
    int cnt;

    tim_a = '{640, 16, 96, 48, 480, 10, 2, 33};
    tim_b = '{8, 2, 3, 2, 6, 2, 2, 1};
    m_a   = '{1'b0, 0, 0};
    m_b   = '{1'b0, 0, 0};

    vecs_a = '{
      '{0,   0, 5'b11101}, '{1,   0, 5'b11100}, '{639, 0, 5'b11100},
      '{640, 0, 5'b11000}, '{655, 0, 5'b11000}, '{656, 0, 5'b01000},
      '{751, 0, 5'b01000}, '{752, 0, 5'b11000}, '{799, 0, 5'b11010},
      '{0,   1, 5'b11100}, '{300, 1, 5'b11100}
    };
    vecs_b = '{
      '{7,  5, 5'b11100}, '{8,  5, 5'b11000}, '{9,  5, 5'b11000},
      '{10, 5, 5'b01000}, '{12, 5, 5'b01000}, '{13, 5, 5'b11000},
      '{14, 5, 5'b11010}, '{0,  6, 5'b11000}, '{3,  7, 5'b11000},
      '{0,  8, 5'b10000}, '{14, 9, 5'b10010}, '{0, 10, 5'b11000},
      '{14, 10, 5'b11010}, '{0, 0, 5'b11101}
    };

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_a", 32'(act_a), 32'({1'b1, 1'b1, 3'b000, 20'd0}));
    check("reset_b", 32'(act_b), 32'({1'b1, 1'b1, 3'b000, 20'd0}));

    rst_n = 1'b1;
    foreach (vecs_a[i]) begin
      run_to(1'b0, vecs_a[i].x, vecs_a[i].y);
      check($sformatf("vec_a(%0d,%0d)", vecs_a[i].x, vecs_a[i].y),
            32'({vga_a.hsync, vga_a.vsync, vga_a.video_on, vga_a.line_end, vga_a.frame_start}),
            32'(vecs_a[i].f));
    end

    // Mid-frame reset for one clock, then HOLD, then restart at the origin.
    rst_n = 1'b0;
    tick();
    check("midrst_vals", 32'(act_a), 32'({1'b1, 1'b1, 3'b000, 20'd0}));
    rst_n = 1'b1;
    tick();
    check("midrst_first", 32'(act_a), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0}));
    tick();
    check("midrst_x1", 32'({vga_a.pixel_x, vga_a.frame_start}), 32'({10'd1, 1'b0}));

    foreach (vecs_b[i]) begin
      run_to(1'b1, vecs_b[i].x, vecs_b[i].y);
      check($sformatf("vec_b(%0d,%0d)", vecs_b[i].x, vecs_b[i].y),
            32'({vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.line_end, vga_b.frame_start}),
            32'(vecs_b[i].f));
    end

    // Clocks from one frame_start pulse to the next: 15 x 11 on the small timing.
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!vga_b.frame_start && cnt < 400);
    check("frame_period_b", 32'(cnt), 32'd165);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
